ahb_apb_bridge_param: RTL

Parametrised AHB-Lite slave to APB4 master bridge. It is the next generation of the single-slot-width BFM bridge, with these additions:
- configurable slot count and decode field
- APB4 PSTRB/PPROT generation
- PREADY timeout
- decode-miss error
- spec-correct two-cycle AHB ERROR response

It sits between the AHB BFM/fabric and up to 16 APB peripherals.

---
 rtl/ahb_apb_bridge_param_pkg.sv | 34 +++
 rtl/ahb_apb_bridge_param_if.sv | 46 ++++
 rtl/ahb_apb_bridge_param_strb_gen.sv | 24 ++
 rtl/ahb_apb_bridge_param.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/ahb_apb_bridge_param_pkg.sv
// Shared types and constants for the parametrised AHB-Lite to APB4 bridge.
package ahb_apb_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SETUP  = 3'd1,
    ACCESS = 3'd2,
    ERR1   = 3'd3,
    ERR2   = 3'd4
  } state_e;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

  localparam logic [2:0] HSIZE_BYTE = 3'd0;
  localparam logic [2:0] HSIZE_HALF = 3'd1;
  localparam logic [2:0] HSIZE_WORD = 3'd2;

  localparam int PPROT_PRIV  = 0;
  localparam int PPROT_NSEC  = 1;
  localparam int PPROT_INSTR = 2;

  // HPROT[0] is data/opcode, HPROT[1] is privileged; the bridge never
  // issues non-secure accesses.
  function automatic logic [2:0] hprot_to_pprot(input logic [1:0] hprot_lo);
    logic [2:0] p;
    p              = '0;
    p[PPROT_PRIV]  = hprot_lo[1];
    p[PPROT_NSEC]  = 1'b0;
    p[PPROT_INSTR] = ~hprot_lo[0];
    return p;
  endfunction

endpackage

// File: rtl/ahb_apb_bridge_param_if.sv
// Bus bundle for the bridge: AHB-Lite slave side plus APB4 master side.
interface ahb_apb_bridge_param_if #(
  parameter int ADDR_W    = 32,
  parameter int NUM_SLOTS = 16
);

  logic              HSEL;
  logic              HWRITE;
  logic [ADDR_W-1:0] HADDR;
  logic [31:0]       HWDATA;
  logic [1:0]        HTRANS;
  logic [2:0]        HSIZE;
  logic [3:0]        HPROT;
  logic              HREADYIN;
  logic [31:0]       HRDATA;
  logic              HREADYOUT;
  logic              HRESP;

  logic [NUM_SLOTS-1:0] PSEL;
  logic [ADDR_W-1:0]    PADDR;
  logic                 PWRITE;
  logic                 PENABLE;
  logic [31:0]          PWDATA;
  logic [3:0]           PSTRB;
  logic [2:0]           PPROT;
  logic [31:0]          PRDATA;
  logic                 PREADY;
  logic                 PSLVERR;

  // Bridge view: receives AHB requests and APB responses.
  modport slave (
    input  HSEL, HWRITE, HADDR, HWDATA, HTRANS, HSIZE, HPROT, HREADYIN,
    input  PRDATA, PREADY, PSLVERR,
    output HRDATA, HREADYOUT, HRESP,
    output PSEL, PADDR, PWRITE, PENABLE, PWDATA, PSTRB, PPROT
  );

  // Environment view: AHB master plus APB peripherals.
  modport master (
    output HSEL, HWRITE, HADDR, HWDATA, HTRANS, HSIZE, HPROT, HREADYIN,
    output PRDATA, PREADY, PSLVERR,
    input  HRDATA, HREADYOUT, HRESP,
    input  PSEL, PADDR, PWRITE, PENABLE, PWDATA, PSTRB, PPROT
  );

endinterface

// File: rtl/ahb_apb_bridge_param_strb_gen.sv
// APB4 byte-strobe generation from the registered AHB size and address.
module apb_strb_gen
  import ahb_apb_pkg::*;
(
  input  logic [2:0] hsize,
  input  logic [1:0] addr_lo,
  input  logic       hwrite,
  output logic [3:0] pstrb
);

  // Reads never drive strobes; writes light the lanes covered by the access.
  always_comb begin
    pstrb = 4'h0;
    if (hwrite) begin
      case (hsize)
        HSIZE_BYTE: pstrb = 4'b0001 << addr_lo;
        HSIZE_HALF: pstrb = 4'b0011 << {addr_lo[1], 1'b0};
        HSIZE_WORD: pstrb = 4'hF;
        default:    pstrb = 4'hF;
      endcase
    end
  end

endmodule

// File: rtl/ahb_apb_bridge_param.sv
// Parametrised AHB-Lite slave to APB4 master bridge with slot decode,
// decode-miss / PSLVERR / PREADY-timeout errors and two-cycle AHB ERROR.
// SLOT_LSB + 4 must not exceed ADDR_W.
module ahb_apb_bridge_param
  import ahb_apb_pkg::*;
#(
  parameter int NUM_SLOTS = 16,
  parameter int SLOT_LSB  = 24,
  parameter int ADDR_W    = 32,
  parameter int TIMEOUT   = 0,
  parameter int TPD       = 1
) (
  input logic                    HCLK,
  input logic                    HRESETN,
  ahb_apb_bridge_param_if.slave  bus
);

  // Output delay only matters to the behavioural model this replaces.
  localparam int unused_tpd = TPD;

  localparam int                   CNT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0]     CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;
  localparam logic [4:0]           SLOTS_N  = 5'(NUM_SLOTS);
  localparam logic [NUM_SLOTS-1:0] SEL_ONE  = 1;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                write_q, write_d;
  logic [2:0]          size_q, size_d;
  logic [2:0]          pprot_q, pprot_d;
  logic [31:0]         pwdata_q, pwdata_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;

  logic                accept;
  logic                take;
  logic [3:0]          slot_in;
  logic [3:0]          slot_q;
  logic                miss_in;
  logic [NUM_SLOTS-1:0] psel;
  logic                penable;
  logic                hreadyout;
  logic                hresp;
  logic [31:0]         pwdata_o;
  logic [3:0]          pstrb;
  logic [2:0]          unused_bits;

  assign unused_bits = {bus.HTRANS[0], bus.HPROT[3:2]};

  assign accept  = bus.HSEL & bus.HREADYIN & bus.HTRANS[1];
  assign slot_in = bus.HADDR[SLOT_LSB+3:SLOT_LSB];
  assign slot_q  = addr_q[SLOT_LSB+3:SLOT_LSB];
  assign miss_in = ({1'b0, slot_in} >= SLOTS_N);

  // Next-state logic: sequencing, address capture and the PREADY wait counter.
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    write_d  = write_q;
    size_d   = size_q;
    pprot_d  = pprot_q;
    pwdata_d = pwdata_q;
    cnt_d    = cnt_q;
    take     = 1'b0;

    case (state_q)
      IDLE: begin
        if (accept) begin
          take    = 1'b1;
          state_d = miss_in ? ERR1 : SETUP;
        end
      end
      SETUP: begin
        state_d = ACCESS;
        cnt_d   = '0;
        if (write_q) pwdata_d = bus.HWDATA;
      end
      ACCESS: begin
        if (bus.PREADY) begin
          if (bus.PSLVERR) begin
            state_d = ERR1;
          end else if (accept) begin
            take    = 1'b1;
            state_d = miss_in ? ERR1 : SETUP;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
          if ((TIMEOUT > 0) && (cnt_q == CNT_LAST)) state_d = ERR1;
        end
      end
      ERR1:    state_d = ERR2;
      ERR2:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (take) begin
      addr_d  = bus.HADDR;
      write_d = bus.HWRITE;
      size_d  = bus.HSIZE;
      pprot_d = hprot_to_pprot(bus.HPROT[1:0]);
    end
  end

  // State and captured-transfer registers; reset clears the APB side at once.
  always_ff @(posedge HCLK or negedge HRESETN) begin
    if (!HRESETN) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      write_q  <= 1'b0;
      size_q   <= '0;
      pprot_q  <= '0;
      pwdata_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      write_q  <= write_d;
      size_q   <= size_d;
      pprot_q  <= pprot_d;
      pwdata_q <= pwdata_d;
      cnt_q    <= cnt_d;
    end
  end

  // Per-state bus outputs; HREADYOUT in ACCESS follows PREADY combinationally.
  always_comb begin
    psel      = '0;
    penable   = 1'b0;
    hreadyout = 1'b1;
    hresp     = 1'b0;
    pwdata_o  = pwdata_q;
    case (state_q)
      SETUP: begin
        psel      = SEL_ONE << slot_q;
        hreadyout = 1'b0;
        pwdata_o  = bus.HWDATA;
      end
      ACCESS: begin
        psel      = SEL_ONE << slot_q;
        penable   = 1'b1;
        hreadyout = bus.PREADY & ~bus.PSLVERR;
      end
      ERR1: begin
        hresp     = 1'b1;
        hreadyout = 1'b0;
      end
      ERR2: begin
        hresp     = 1'b1;
      end
      default: ;
    endcase
  end

  apb_strb_gen u_strb (
    .hsize   (size_q),
    .addr_lo (addr_q[1:0]),
    .hwrite  (write_q),
    .pstrb   (pstrb)
  );

  assign bus.HRDATA    = bus.PRDATA;
  assign bus.HREADYOUT = hreadyout;
  assign bus.HRESP     = hresp;
  assign bus.PSEL      = psel;
  assign bus.PADDR     = addr_q;
  assign bus.PWRITE    = write_q;
  assign bus.PENABLE   = penable;
  assign bus.PWDATA    = pwdata_o;
  assign bus.PSTRB     = pstrb;
  assign bus.PPROT     = pprot_q;

endmodule
